univ_shift_reg: RTL and testbench

Parametrised successor to the team's fixed 8-bit clearable register. It is a WIDTH-bit universal register supporting load, clear, logical/arithmetic shift and rotate. Shift and rotate operations take multiple cycles, one bit per cycle, with a Start/Busy/Done handshake. It sits between datapath sources (switches, BRAM douta) and display/ALU consumers in the lab designs.

---
 rtl/univ_shift_reg_pkg.sv | 29 ++
 rtl/univ_shift_reg_shift_step.sv | 43 ++++
 rtl/univ_shift_reg.sv | 111 +++++++++++
 tb/tb_univ_shift_reg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes, FSM states
// and a constant-evaluable ceil(log2) used for parameter defaults.
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// Combinational single-step shifter: next register value and the bit shifted out
// for one shift/rotate step of the selected mode.
module univ_shift_reg_shift_step
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e              i_mode,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_ser_in,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_ser_out
);

  always_comb begin
    o_data    = i_data;
    o_ser_out = 1'b0;
    case (i_mode)
      MODE_SHL: begin
        o_data    = {i_data[WIDTH-2:0], i_ser_in};
        o_ser_out = i_data[WIDTH-1];
      end
      MODE_SHR: begin
        o_data    = {i_ser_in, i_data[WIDTH-1:1]};
        o_ser_out = i_data[0];
      end
      MODE_ROTL: begin
        o_data    = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
        o_ser_out = i_data[WIDTH-1];
      end
      MODE_ROTR: begin
        o_data    = {i_data[0], i_data[WIDTH-1:1]};
        o_ser_out = i_data[0];
      end
      MODE_ASR: begin
        o_data    = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
        o_ser_out = i_data[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: load/clear in one cycle, shifts and rotates one
// bit per cycle under a Start/Busy/Done handshake.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [AMT_W-1:0] Amt,
  input  logic             SerIn,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done,
  output logic             Zero
);

  state_e           r_state, w_state_nxt;
  mode_e            r_mode, w_mode_nxt;
  logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_ser, w_ser_nxt;
  logic             r_done;
  logic [AMT_W-1:0] w_amt_sat;
  logic [WIDTH-1:0] w_step_out;
  logic             w_step_ser;

  univ_shift_reg_shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .i_mode    (r_mode),
    .i_data    (r_out),
    .i_ser_in  (SerIn),
    .o_data    (w_step_out),
    .o_ser_out (w_step_ser)
  );

  assign w_amt_sat = (Amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : Amt;

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_ser_nxt   = r_ser;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          case (mode_e'(Mode))
            MODE_HOLD: w_state_nxt = ST_DONE;
            MODE_LOAD: begin
              w_out_nxt   = IN;
              w_state_nxt = ST_DONE;
            end
            MODE_CLR: begin
              w_out_nxt   = '0;
              w_ser_nxt   = 1'b0;
              w_state_nxt = ST_DONE;
            end
            default: begin
              if (Amt == '0) begin
                w_state_nxt = ST_DONE;
              end else begin
                w_mode_nxt  = mode_e'(Mode);
                w_cnt_nxt   = w_amt_sat;
                w_state_nxt = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        w_out_nxt = w_step_out;
        w_ser_nxt = w_step_ser;
        w_cnt_nxt = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Done is a flop loaded on entry to DONE, so it is high exactly while in DONE.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_out   <= '0;
      r_ser   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_ser   <= w_ser_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign OUT    = r_out;
  assign SerOut = r_ser;
  assign Busy   = (r_state != ST_IDLE);
  assign Done   = r_done;
  assign Zero   = (r_out == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8) against an arithmetic model.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic       Clk;
  logic       Clear;
  logic       Start;
  logic [2:0] Mode;
  logic [3:0] Amt;
  logic       SerIn;
  logic [7:0] IN;
  logic [7:0] OUT;
  logic       SerOut;
  logic       Busy;
  logic       Done;
  logic       Zero;

  int checks;
  int failures;

  logic [7:0] m_out;
  logic       m_ser;

  univ_shift_reg #(.WIDTH(W), .AMT_W(4)) dut (
    .Clk    (Clk),
    .Clear  (Clear),
    .Start  (Start),
    .Mode   (Mode),
    .Amt    (Amt),
    .SerIn  (SerIn),
    .IN     (IN),
    .OUT    (OUT),
    .SerOut (SerOut),
    .Busy   (Busy),
    .Done   (Done),
    .Zero   (Zero)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // One step of the reference model, in plain integer arithmetic; returns {ser, value}.
  function automatic logic [8:0] model_step(input int mode, input int v, input int s);
    int nv;
    int so;
    nv = v;
    so = 0;
    case (mode)
      2: begin nv = (v * 2 + s) % 256;            so = v / 128; end
      3: begin nv = v / 2 + s * 128;              so = v % 2;   end
      4: begin nv = (v * 2) % 256 + v / 128;      so = v / 128; end
      5: begin nv = v / 2 + (v % 2) * 128;        so = v % 2;   end
      6: begin nv = v / 2 + ((v >= 128) ? 128 : 0); so = v % 2; end
      default: ;
    endcase
    return {so[0], nv[7:0]};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one operation and follow it to completion, checking every cycle.
  task automatic run_op(input int mode, input int amt, input logic [7:0] din,
                        input int ser_sel, input string tag);
    int n;
    int s;
    logic [8:0] r;
    Mode  = mode[2:0];
    Amt   = amt[3:0];
    IN    = din;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Mode  = 3'($urandom);
    Amt   = 4'($urandom);
    IN    = 8'($urandom);
    n = (mode >= 2 && mode <= 6) ? ((amt > W) ? W : amt) : 0;
    if (mode == 1) m_out = din;
    if (mode == 7) begin m_out = 8'h00; m_ser = 1'b0; end
    checks++;
    if (OUT !== m_out || SerOut !== m_ser || Busy !== 1'b1 || Done !== (n == 0) || Zero !== (m_out == 0)) begin
      failures++;
      $display("FAIL %s start: OUT=%h SerOut=%b Busy=%b Done=%b Zero=%b required OUT=%h SerOut=%b Busy=1 Done=%b Zero=%b",
               tag, OUT, SerOut, Busy, Done, Zero, m_out, m_ser, (n == 0), (m_out == 0));
    end
    for (int k = 1; k <= n; k++) begin
      s = (ser_sel == 2) ? int'($urandom_range(0, 1)) : ser_sel;
      SerIn = s[0];
      tick();
      r = model_step(mode, int'(m_out), s);
      m_out = r[7:0];
      m_ser = r[8];
      checks++;
      if (OUT !== m_out || SerOut !== m_ser || Busy !== 1'b1 || Done !== (k == n) || Zero !== (m_out == 0)) begin
        failures++;
        $display("FAIL %s step %0d: OUT=%h SerOut=%b Busy=%b Done=%b required OUT=%h SerOut=%b Busy=1 Done=%b",
                 tag, k, OUT, SerOut, Busy, Done, m_out, m_ser, (k == n));
      end
    end
    tick();
    checks++;
    if (OUT !== m_out || SerOut !== m_ser || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL %s end: OUT=%h SerOut=%b Busy=%b Done=%b required OUT=%h SerOut=%b Busy=0 Done=0",
               tag, OUT, SerOut, Busy, Done, m_out, m_ser);
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    repeat (2) tick();
    m_out = 8'h00;
    m_ser = 1'b0;
    checks++;
    if (OUT !== 8'h00 || SerOut !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL reset: OUT=%h SerOut=%b Busy=%b Done=%b Zero=%b required 00 0 0 0 1",
               OUT, SerOut, Busy, Done, Zero);
    end
    Clear = 1'b0;
    tick();
    checks++;
    if (OUT !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: OUT=%h Busy=%b Done=%b required 00 0 0", OUT, Busy, Done);
    end
  endtask

  task automatic test_load();
    run_op(1, 0, 8'hA5, 0, "load_a5");
    checks++;
    if (OUT !== 8'hA5) begin
      failures++;
      $display("FAIL load_value: OUT=%h required a5", OUT);
    end
  endtask

  task automatic test_rotate();
    run_op(1, 0, 8'h81, 0, "load_81");
    run_op(4, 3, 8'h00, 0, "rotl3");
    checks++;
    if (OUT !== 8'h0C || SerOut !== 1'b0) begin
      failures++;
      $display("FAIL rotl3_final: OUT=%h SerOut=%b required 0c 0", OUT, SerOut);
    end
    run_op(1, 0, 8'h81, 0, "load_81b");
    run_op(4, 8, 8'h00, 0, "rotl8");
    checks++;
    if (OUT !== 8'h81) begin
      failures++;
      $display("FAIL rotl8_restore: OUT=%h required 81", OUT);
    end
    run_op(5, 8, 8'h00, 0, "rotr8");
    checks++;
    if (OUT !== 8'h81) begin
      failures++;
      $display("FAIL rotr8_restore: OUT=%h required 81", OUT);
    end
  endtask

  task automatic test_shift_right();
    run_op(1, 0, 8'h90, 0, "load_90");
    run_op(6, 2, 8'h00, 0, "asr2");
    checks++;
    if (OUT !== 8'hE4 || SerOut !== 1'b0) begin
      failures++;
      $display("FAIL asr2_final: OUT=%h SerOut=%b required e4 0", OUT, SerOut);
    end
    run_op(1, 0, 8'h01, 0, "load_01");
    run_op(3, 1, 8'h00, 1, "shr1");
    checks++;
    if (OUT !== 8'h80 || SerOut !== 1'b1) begin
      failures++;
      $display("FAIL shr1_final: OUT=%h SerOut=%b required 80 1", OUT, SerOut);
    end
  endtask

  task automatic test_busy_and_abort();
    logic [8:0] r;
    int s;
    run_op(1, 0, 8'h3C, 0, "load_3c");
    Mode = 3'd2; Amt = 4'd5; Start = 1'b1;
    tick();
    // A second Start (LOAD) during SHIFT must be ignored.
    Mode = 3'd1; IN = 8'h00; Start = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      s = int'($urandom_range(0, 1));
      SerIn = s[0];
      tick();
      Start = 1'b0;
      r = model_step(2, int'(m_out), s);
      m_out = r[7:0];
      m_ser = r[8];
      checks++;
      if (OUT !== m_out || SerOut !== m_ser || Busy !== 1'b1 || Done !== 1'b0) begin
        failures++;
        $display("FAIL busy_ignore step %0d: OUT=%h SerOut=%b Busy=%b Done=%b required OUT=%h SerOut=%b Busy=1 Done=0",
                 k, OUT, SerOut, Busy, Done, m_out, m_ser);
      end
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    m_out = 8'h00;
    m_ser = 1'b0;
    checks++;
    if (OUT !== 8'h00 || SerOut !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL abort: OUT=%h SerOut=%b Busy=%b Done=%b required 00 0 0 0", OUT, SerOut, Busy, Done);
    end
    tick();
    checks++;
    if (OUT !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: OUT=%h Busy=%b Done=%b required 00 0 0", OUT, Busy, Done);
    end
  endtask

  task automatic test_amt_edges();
    run_op(1, 0, 8'hFF, 0, "load_ff");
    run_op(2, 0, 8'h00, 0, "shl_amt0");
    checks++;
    if (OUT !== 8'hFF) begin
      failures++;
      $display("FAIL shl_amt0_value: OUT=%h required ff", OUT);
    end
    run_op(2, 15, 8'h00, 0, "shl_amt15");
    checks++;
    if (OUT !== 8'h00 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL shl_sat_value: OUT=%h Zero=%b required 00 1", OUT, Zero);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 8'($urandom), 2, "random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Clear = 1'b1;
    Start = 1'b0;
    Mode  = 3'd0;
    Amt   = 4'd0;
    SerIn = 1'b0;
    IN    = 8'h00;
    m_out = 8'h00;
    m_ser = 1'b0;
    test_reset();
    test_load();
    test_rotate();
    test_shift_right();
    test_busy_and_abort();
    test_amt_edges();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
